// File: rtl/axi4lite_mst_if.sv
// axi4lite_mst_if: AXI4-Lite bus bundle between the axi4lite_mst initiator and a register slave.
// Channel signal names follow AXI4-Lite with the m_axi_ prefix carried by the instance name.
interface axi4lite_mst_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;

    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;

    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;

    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arprot, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arprot, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi4lite_mst.sv
// axi4lite_mst: single-outstanding command port turned into AXI4-Lite read/write transactions.
// Define AXI4LITE_MST_ERRCNT_EN to build the saturating error-response counter behind err_cnt.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | cmd_ready high, waiting for a command
// ST_WR      | AW and W offered, each dropped after its own handshake
// ST_WR_RESP | bready high, waiting for the write response
// ST_RD      | arvalid held until arready
// ST_RD_DATA | rready high, waiting for read data
module axi4lite_mst #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    s_axi_clk,
    input  logic                    s_axi_resetn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_wr,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic                    busy,
    output logic [15:0]             err_cnt,
    input  logic                    err_cnt_clr,
    axi4lite_mst_if.master          m_axi
);
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_WR_RESP,
        ST_RD,
        ST_RD_DATA
    } state_t;

    state_t                  r_state;
    logic                    r_awvalid;
    logic                    r_wvalid;
    logic                    r_bready;
    logic                    r_arvalid;
    logic                    r_rready;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH/8-1:0] r_wstrb;
    logic                    r_rsp_valid;
    logic [DATA_WIDTH-1:0]   r_rsp_rdata;
    logic [1:0]              r_rsp_resp;

    logic                    w_aw_done;
    logic                    w_w_done;

    // A channel counts as done once its valid is low or it handshakes this cycle.
    assign w_aw_done = !r_awvalid || m_axi.awready;
    assign w_w_done  = !r_wvalid  || m_axi.wready;

    always_ff @(posedge s_axi_clk or negedge s_axi_resetn) begin
        if (!s_axi_resetn) begin
            r_state     <= ST_IDLE;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= 2'b00;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_addr  <= cmd_addr;
                        r_wdata <= cmd_wdata;
                        r_wstrb <= cmd_wstrb;
                        if (cmd_wr) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= ST_WR;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= ST_RD;
                        end
                    end
                end
                ST_WR: begin
                    if (r_awvalid && m_axi.awready) begin
                        r_awvalid <= 1'b0;
                    end
                    if (r_wvalid && m_axi.wready) begin
                        r_wvalid <= 1'b0;
                    end
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                        r_state  <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (m_axi.bvalid) begin
                        r_bready    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_rsp_resp  <= m_axi.bresp;
                        r_state     <= ST_IDLE;
                    end
                end
                ST_RD: begin
                    if (m_axi.arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (m_axi.rvalid) begin
                        r_rready    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= m_axi.rdata;
                        r_rsp_resp  <= m_axi.rresp;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_resp  = r_rsp_resp;

    assign m_axi.awaddr  = r_addr;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.awvalid = r_awvalid;
    assign m_axi.wdata   = r_wdata;
    assign m_axi.wstrb   = r_wstrb;
    assign m_axi.wvalid  = r_wvalid;
    assign m_axi.bready  = r_bready;
    assign m_axi.araddr  = r_addr;
    assign m_axi.arprot  = 3'b000;
    assign m_axi.arvalid = r_arvalid;
    assign m_axi.rready  = r_rready;

`ifdef AXI4LITE_MST_ERRCNT_EN
    logic        w_cpl;
    logic [1:0]  w_cpl_resp;
    logic [15:0] r_err_cnt;

    assign w_cpl      = ((r_state == ST_WR_RESP) && m_axi.bvalid) ||
                        ((r_state == ST_RD_DATA) && m_axi.rvalid);
    assign w_cpl_resp = (r_state == ST_WR_RESP) ? m_axi.bresp : m_axi.rresp;

    // Clear has priority over an increment landing on the same edge.
    always_ff @(posedge s_axi_clk or negedge s_axi_resetn) begin
        if (!s_axi_resetn) begin
            r_err_cnt <= 16'h0000;
        end else if (err_cnt_clr) begin
            r_err_cnt <= 16'h0000;
        end else if (w_cpl && (w_cpl_resp != 2'b00) && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'h0001;
        end
    end

    assign err_cnt = r_err_cnt;
`else
    logic w_unused_err_cnt_clr;

    assign w_unused_err_cnt_clr = err_cnt_clr;
    assign err_cnt              = 16'h0000;
`endif
endmodule

// File: tb/tb_axi4lite_mst.sv
// tb_axi4lite_mst: directed and randomized checks of axi4lite_mst against a transaction-level model
// and a configurable-latency AXI4-Lite slave with a small register memory.
module tb_axi4lite_mst;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_wr = 1'b0;
    logic [31:0] cmd_addr = 32'h0;
    logic [31:0] cmd_wdata = 32'h0;
    logic [3:0]  cmd_wstrb = 4'h0;
    logic        err_cnt_clr = 1'b0;
    logic        cmd_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        busy;
    logic [15:0] err_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic rand_phase = 1'b0;

    axi4lite_mst_if bus ();

    axi4lite_mst dut (
        .s_axi_clk    (clk),
        .s_axi_resetn (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_wr       (cmd_wr),
        .cmd_addr     (cmd_addr),
        .cmd_wdata    (cmd_wdata),
        .cmd_wstrb    (cmd_wstrb),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_resp     (rsp_resp),
        .busy         (busy),
        .err_cnt      (err_cnt),
        .err_cnt_clr  (err_cnt_clr),
        .m_axi        (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [1:0] resp_of(input logic [31:0] a);
        if (a[7:0] == 8'h3C) return 2'b10;
        if (a[7:0] == 8'h38) return 2'b11;
        return 2'b00;
    endfunction

    // ---------------- slave model: each ready/valid appears after a programmable wait
    int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    int b_total;
    logic got_aw, got_w, got_ar;
    logic [31:0] s_awaddr, s_wdata, s_araddr;
    logic [3:0]  s_wstrb;
    logic [31:0] smem [16];

    initial for (int i = 0; i < 16; i++) smem[i] <= 32'h0;

    assign bus.awready = (aw_cnt >= aw_dly);
    assign bus.wready  = (w_cnt >= w_dly);
    assign bus.bvalid  = got_aw && got_w && (b_cnt >= b_dly);
    assign bus.bresp   = resp_of(s_awaddr);
    assign bus.arready = (ar_cnt >= ar_dly);
    assign bus.rvalid  = got_ar && (r_cnt >= r_dly);
    assign bus.rdata   = smem[s_araddr[5:2]];
    assign bus.rresp   = resp_of(s_araddr);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
            got_aw <= 1'b0; got_w <= 1'b0; got_ar <= 1'b0;
            s_awaddr <= 32'h0; s_wdata <= 32'h0; s_wstrb <= 4'h0; s_araddr <= 32'h0;
            b_total <= 0;
        end else begin
            if (bus.awvalid && bus.awready) begin
                got_aw <= 1'b1; s_awaddr <= bus.awaddr; aw_cnt <= 0;
            end else if (bus.awvalid) aw_cnt <= aw_cnt + 1;
            if (bus.wvalid && bus.wready) begin
                got_w <= 1'b1; s_wdata <= bus.wdata; s_wstrb <= bus.wstrb; w_cnt <= 0;
            end else if (bus.wvalid) w_cnt <= w_cnt + 1;
            if (bus.bvalid && bus.bready) begin
                if (resp_of(s_awaddr) == 2'b00)
                    for (int i = 0; i < 4; i++)
                        if (s_wstrb[i]) smem[s_awaddr[5:2]][8*i +: 8] <= s_wdata[8*i +: 8];
                got_aw <= 1'b0; got_w <= 1'b0; b_cnt <= 0; b_total <= b_total + 1;
            end else if (got_aw && got_w) b_cnt <= b_cnt + 1;
            if (bus.arvalid && bus.arready) begin
                got_ar <= 1'b1; s_araddr <= bus.araddr; ar_cnt <= 0;
            end else if (bus.arvalid) ar_cnt <= ar_cnt + 1;
            if (bus.rvalid && bus.rready) begin
                got_ar <= 1'b0; r_cnt <= 0;
            end else if (got_ar) r_cnt <= r_cnt + 1;
        end
    end

    // ---------------- transaction-level reference model and per-cycle compare
    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] rdata;
        logic [1:0]  resp;
    } txn_t;

    txn_t        q[$];
    txn_t        h_cur, h_new;
    logic [31:0] mmem [16];
    logic        txn_open = 1'b0, cpl_pend = 1'b0, prev_clr = 1'b0, exp_rsp, err_inc;
    logic [31:0] m_last_rdata = 32'h0;
    logic [1:0]  m_last_resp = 2'b00;
    logic [15:0] m_err = 16'h0;
    int n_aw, n_w, n_b, n_ar, n_r;
    int rsp_count = 0, last_rsp_cyc = 0, prev_rsp_cyc = 0;
    logic        p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_bre, p_bv, p_rre, p_rv;
    logic [31:0] p_awaddr, p_wdata, p_araddr;
    logic [3:0]  p_wstrb;

    initial for (int i = 0; i < 16; i++) mmem[i] = 32'h0;

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            txn_open = 1'b0; cpl_pend = 1'b0; prev_clr = 1'b0;
            m_last_rdata = 32'h0; m_last_resp = 2'b00; m_err = 16'h0;
            {p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_bre, p_bv, p_rre, p_rv} = '0;
        end else begin
            exp_rsp = cpl_pend;
            err_inc = 1'b0;
            chk("rsp_valid", rsp_valid, exp_rsp);
            if (rsp_valid) begin
                rsp_count++;
                prev_rsp_cyc = last_rsp_cyc;
                last_rsp_cyc = cyc;
            end
            if (exp_rsp) begin
                chk("rsp_queue_size", q.size(), 1);
                if (q.size() > 0) begin
                    h_cur = q.pop_front();
                    chk("rsp_rdata", rsp_rdata, h_cur.rdata);
                    chk("rsp_resp", rsp_resp, h_cur.resp);
                    chk("aw_count", n_aw, h_cur.wr ? 1 : 0);
                    chk("w_count", n_w, h_cur.wr ? 1 : 0);
                    chk("b_count", n_b, h_cur.wr ? 1 : 0);
                    chk("ar_count", n_ar, h_cur.wr ? 0 : 1);
                    chk("r_count", n_r, h_cur.wr ? 0 : 1);
                    m_last_rdata = h_cur.rdata;
                    m_last_resp = h_cur.resp;
                    err_inc = (h_cur.resp != 2'b00);
                end
                txn_open = 1'b0;
            end else begin
                chk("rsp_rdata_hold", rsp_rdata, m_last_rdata);
                chk("rsp_resp_hold", rsp_resp, m_last_resp);
            end
            if (prev_clr) m_err = 16'h0;
            else if (err_inc && m_err != 16'hFFFF) m_err = m_err + 16'h1;
`ifdef AXI4LITE_MST_ERRCNT_EN
            chk("err_cnt", err_cnt, m_err);
`else
            chk("err_cnt_off", err_cnt, 16'h0);
`endif
            chk("busy", busy, txn_open);
            chk("cmd_ready", cmd_ready, !txn_open);

            if (p_awv && !p_awr) begin
                chk("awvalid_hold", bus.awvalid, 1);
                chk("awaddr_stable", bus.awaddr, p_awaddr);
            end
            if (p_wv && !p_wr) begin
                chk("wvalid_hold", bus.wvalid, 1);
                chk("wdata_stable", bus.wdata, p_wdata);
                chk("wstrb_stable", bus.wstrb, p_wstrb);
            end
            if (p_arv && !p_arr) begin
                chk("arvalid_hold", bus.arvalid, 1);
                chk("araddr_stable", bus.araddr, p_araddr);
            end
            if (p_bre && !p_bv) chk("bready_hold", bus.bready, 1);
            if (p_rre && !p_rv) chk("rready_hold", bus.rready, 1);

            if (bus.awvalid && bus.awready) begin
                n_aw++;
                chk("aw_in_txn", txn_open, 1);
                if (txn_open) chk("awaddr", bus.awaddr, q[0].addr);
                chk("awprot", bus.awprot, 0);
            end
            if (bus.wvalid && bus.wready) begin
                n_w++;
                chk("w_in_txn", txn_open, 1);
                if (txn_open) begin
                    chk("wdata", bus.wdata, q[0].wdata);
                    chk("wstrb", bus.wstrb, q[0].strb);
                end
            end
            if (bus.bvalid && bus.bready) n_b++;
            if (bus.arvalid && bus.arready) begin
                n_ar++;
                chk("ar_in_txn", txn_open, 1);
                if (txn_open) chk("araddr", bus.araddr, q[0].addr);
                chk("arprot", bus.arprot, 0);
            end
            if (bus.rvalid && bus.rready) n_r++;
            cpl_pend = (bus.bvalid && bus.bready) || (bus.rvalid && bus.rready);

            if (cmd_valid && !txn_open) begin
                h_new.wr = cmd_wr;
                h_new.addr = cmd_addr;
                h_new.wdata = cmd_wdata;
                h_new.strb = cmd_wstrb;
                h_new.resp = resp_of(cmd_addr);
                h_new.rdata = cmd_wr ? 32'h0 : mmem[cmd_addr[5:2]];
                if (cmd_wr && h_new.resp == 2'b00)
                    for (int i = 0; i < 4; i++)
                        if (cmd_wstrb[i]) mmem[cmd_addr[5:2]][8*i +: 8] = cmd_wdata[8*i +: 8];
                q.push_back(h_new);
                txn_open = 1'b1;
                n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0;
            end
            prev_clr = err_cnt_clr;
            p_awv = bus.awvalid; p_awr = bus.awready; p_awaddr = bus.awaddr;
            p_wv = bus.wvalid; p_wr = bus.wready; p_wdata = bus.wdata; p_wstrb = bus.wstrb;
            p_arv = bus.arvalid; p_arr = bus.arready; p_araddr = bus.araddr;
            p_bre = bus.bready; p_bv = bus.bvalid; p_rre = bus.rready; p_rv = bus.rvalid;
        end
    end

    // ---------------- stimulus
    task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output int t_acc);
        int n;
        n = 0;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        @(negedge clk);
        while (!cmd_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_accept", cmd_ready, 1);
        t_acc = cyc;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_wdata = $urandom;
    endtask

    task automatic wait_rsp(input int target);
        int n;
        n = 0;
        while (rsp_count < target && n < 500) begin
            @(negedge clk); #1;
            n++;
        end
        chk("rsp_arrived", rsp_count >= target, 1);
    endtask

    initial forever begin
        @(posedge clk); #1;
        if (rand_phase) err_cnt_clr = ($urandom_range(0, 9) == 0);
    end

    initial begin
        #400000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, base;
        logic [31:0] d;

        repeat (3) @(negedge clk);
        chk("rst_awvalid", bus.awvalid, 0);
        chk("rst_wvalid", bus.wvalid, 0);
        chk("rst_bready", bus.bready, 0);
        chk("rst_arvalid", bus.arvalid, 0);
        chk("rst_rready", bus.rready, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_resp", rsp_resp, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_awaddr", bus.awaddr, 0);
        chk("rst_wdata", bus.wdata, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // zero-wait write then read of 0x08
        base = rsp_count;
        issue(1'b1, 32'h08, 32'h5A5A_1234, 4'hF, t0);
        wait_rsp(base + 1);
        chk("t1_wr_latency", last_rsp_cyc - t0, 3);
        chk("t1_awaddr", s_awaddr, 32'h08);
        chk("t1_wdata", s_wdata, 32'h5A5A_1234);
        chk("t1_wstrb", s_wstrb, 4'hF);
        issue(1'b0, 32'h08, 32'h0, 4'h0, t0);
        wait_rsp(base + 2);
        chk("t1_rd_latency", last_rsp_cyc - t0, 3);
        chk("t1_rdata", rsp_rdata, 32'h5A5A_1234);
        chk("t1_resp", rsp_resp, 0);

        // W before AW, then AW before W
        aw_dly = 3; w_dly = 0;
        base = rsp_count; t1 = b_total;
        issue(1'b1, 32'h10, 32'hCAFE_0001, 4'hF, t0);
        wait_rsp(base + 1);
        chk("t2a_latency", last_rsp_cyc - t0, 6);
        chk("t2a_b_once", b_total - t1, 1);
        aw_dly = 0; w_dly = 3;
        base = rsp_count; t1 = b_total;
        issue(1'b1, 32'h10, 32'hCAFE_0002, 4'h3, t0);
        wait_rsp(base + 1);
        chk("t2b_latency", last_rsp_cyc - t0, 6);
        chk("t2b_b_once", b_total - t1, 1);
        w_dly = 0;

        // slow B, then slow R, with ignored command pulses while busy
        b_dly = 10;
        base = rsp_count;
        issue(1'b1, 32'h14, 32'h1357_9BDF, 4'hF, t0);
        repeat (3) @(posedge clk);
        #1 cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 32'h20;
        @(posedge clk); #1 cmd_valid = 1'b0;
        wait_rsp(base + 1);
        chk("t3_b_latency", last_rsp_cyc - t0, 13);
        b_dly = 0; r_dly = 7;
        base = rsp_count;
        issue(1'b0, 32'h10, 32'h0, 4'h0, t0);
        repeat (2) @(posedge clk);
        #1 cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 32'h24;
        @(posedge clk); #1 cmd_valid = 1'b0;
        wait_rsp(base + 1);
        chk("t3_r_latency", last_rsp_cyc - t0, 10);
        chk("t3_rdata", rsp_rdata, 32'hCAFE_0002);
        r_dly = 0;

        // SLVERR on 0x3C and clear colliding with a second error
        @(posedge clk); #1 err_cnt_clr = 1'b1;
        @(posedge clk); #1 err_cnt_clr = 1'b0;
        base = rsp_count;
        issue(1'b0, 32'h3C, 32'h0, 4'h0, t0);
        wait_rsp(base + 1);
        chk("t4_resp", rsp_resp, 2'b10);
`ifdef AXI4LITE_MST_ERRCNT_EN
        chk("t4_err_cnt_one", err_cnt, 1);
`else
        chk("t4_err_cnt_off", err_cnt, 0);
`endif
        issue(1'b0, 32'h3C, 32'h0, 4'h0, t0);
        @(posedge clk); #1 err_cnt_clr = 1'b1;
        @(posedge clk); #1 err_cnt_clr = 1'b0;
        wait_rsp(base + 2);
        chk("t4_resp2", rsp_resp, 2'b10);
        chk("t4_err_cnt_cleared", err_cnt, 0);

        // reset while waiting on arready
        ar_dly = 1000;
        issue(1'b0, 32'h14, 32'h0, 4'h0, t0);
        @(posedge clk); #1;
        chk("t5_arvalid_before", bus.arvalid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_arvalid_async", bus.arvalid, 0);
        chk("t5_busy", busy, 0);
        chk("t5_cmd_ready", cmd_ready, 1);
        chk("t5_rsp_valid", rsp_valid, 0);
        repeat (2) @(negedge clk);
        ar_dly = 0;
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        base = rsp_count;
        issue(1'b1, 32'h0C, 32'hA5A5_0F0F, 4'hF, t0);
        wait_rsp(base + 1);
        chk("t5_wr_latency", last_rsp_cyc - t0, 3);
        chk("t5_wr_resp", rsp_resp, 0);

        // back-to-back read then write
        base = rsp_count;
        issue(1'b0, 32'h0C, 32'h0, 4'h0, t0);
        issue(1'b1, 32'h18, 32'h7777_8888, 4'hF, t1);
        wait_rsp(base + 2);
        chk("t6_accept_gap", t1 - t0, 3);
        chk("t6_first_rsp_at_accept", prev_rsp_cyc, t1);
        chk("t6_rsp_spacing", last_rsp_cyc - prev_rsp_cyc, 3);

        // randomized traffic
        rand_phase = 1'b1;
        for (int k = 0; k < 120; k++) begin
            aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
            b_dly = $urandom_range(0, 4); ar_dly = $urandom_range(0, 3);
            r_dly = $urandom_range(0, 4);
            base = rsp_count;
            d = $urandom;
            issue($urandom_range(0, 1) == 1, 32'($urandom_range(0, 15) * 4), d,
                  4'($urandom_range(0, 15)), t0);
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                issue($urandom_range(0, 1) == 1, 32'($urandom_range(0, 15) * 4), d,
                      4'($urandom_range(0, 15)), t1);
                wait_rsp(base + 2);
            end else begin
                wait_rsp(base + 1);
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        rand_phase = 1'b0;
        err_cnt_clr = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi4lite_mst.md
Name: axi4lite_mst

Overview:
- AXI4-Lite master (initiator) that turns a simple single-outstanding command port into AXI4-Lite read/write transactions.
- Drives the register slaves in the design, e.g. user logic behind the AXI4-Lite register controller, from internal sequencers or test logic that have no bus master of their own.
- One transaction in flight at a time; response (read data + resp code) returned on a one-cycle pulse.

Parameters:
- ADDR_WIDTH, 32, width of cmd_addr and m_axi_awaddr/m_axi_araddr.
- DATA_WIDTH, 32, data width; fixed at 32, other values unsupported.

Ports:
- s_axi_clk  in  1  clock, all logic on rising edge.
- s_axi_resetn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; command accepted on cmd_valid && cmd_ready.
- cmd_wr  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_wdata  in  32  write data.
- cmd_wstrb  in  4  write byte strobes.
- rsp_valid  out  1  one-cycle completion pulse, no backpressure.
- rsp_rdata  out  32  read data; 0 for writes.
- rsp_resp  out  2  BRESP/RRESP of the completed transaction.
- busy  out  1  high in any state other than IDLE.
- err_cnt  out  16  error counter (Optional Feature).
- err_cnt_clr  in  1  synchronous clear of err_cnt.
- m_axi_awaddr/awprot/awvalid/awready, m_axi_wdata/wstrb/wvalid/wready, m_axi_bresp/bvalid/bready, m_axi_araddr/arprot/arvalid/arready, m_axi_rdata/rresp/rvalid/rready  standard AXI4-Lite master directions and widths.

Behaviour:
- Reset (async assert, sync deassert by the driver): state=IDLE. All *valid/*ready outputs 0, cmd_ready=1, busy=0, rsp_valid=0, rsp_rdata=0, rsp_resp=0, err_cnt=0. Address and data registers reset to 0.
- awprot/arprot tied 3'b000.
- States: IDLE, WR, WR_RESP, RD, RD_DATA.
- IDLE: on cmd accept, register addr/wdata/wstrb.
  - Write: go to WR, with awvalid=wvalid=1 from the next cycle.
  - Read: go to RD, with arvalid=1 from the next cycle.
- WR:
  - awvalid drops the cycle after the awvalid&&awready handshake. wvalid drops independently after its own handshake.
  - Either order and either a simultaneous handshake are legal.
  - Move to WR_RESP when both handshakes are done (including the same cycle). bready=1 in WR_RESP.
- WR_RESP: on bvalid&&bready, bready drops, capture bresp, go to IDLE, rsp_valid=1 for one cycle with rsp_rdata=0.
- RD: arvalid held until arready, then go to RD_DATA with rready=1.
- RD_DATA: on rvalid&&rready, capture rdata/rresp, rsp_valid pulse, go to IDLE.
- AXI rules:
  - Valids never depend combinationally on readys.
  - Addr/data/strb stable while valid is high.
  - Valid never deasserted before its handshake.
- Latency, zero-wait slave (readys high, response the cycle after the handshake):
  - Write: cmd accept at T0, AW/W handshake at T1, B at T2, rsp_valid at T3.
  - Read: same timing, with R at T2 and rsp_valid at T3.
- cmd_ready returns high the same cycle rsp_valid pulses, so back-to-back commands are possible (next accept at T3).
- No timeout: a non-responding slave holds the FSM; only reset recovers. Reset mid-transaction drops all valids immediately and no rsp is produced.
- rsp_rdata/rsp_resp hold their last values until the next completion.

Optional Feature:
- Macro AXI4LITE_MST_ERRCNT_EN.
- Defined: err_cnt increments on each completion with resp != 2'b00 and saturates at 16'hFFFF.
  - err_cnt_clr clears it to 0.
  - Clear wins over a simultaneous increment.
- Undefined: err_cnt tied to 0 and err_cnt_clr ignored; no counter logic is generated.

Test Plan:
- Write 0x5A5A_1234 to 0x08 with strb 4'hF, then read 0x08 against a zero-wait slave model -> awaddr=0x08, wdata=0x5A5A_1234, wstrb=4'hF; rsp_valid at T3 for each transaction; read rsp_rdata=0x5A5A_1234, rsp_resp=0.
- Slave asserts wready 3 cycles before awready, then repeats with awready first -> both valids held until their own handshake; exactly one B accepted; one rsp_valid pulse.
- bvalid delayed 10 cycles, then rvalid delayed 7 cycles -> bready/rready held high throughout; busy=1 and cmd_ready=0 until the respective rsp_valid; cmd_valid pulses during busy ignored.
- Slave returns SLVERR (2'b10) on a read of 0x3C, with ERRCNT_EN defined -> rsp_resp=2'b10, err_cnt=1; err_cnt_clr asserted in the same cycle as a second error -> err_cnt=0.
- Reset asserted while arvalid=1 awaiting arready -> arvalid=0 asynchronously, state IDLE, no rsp_valid; after release a write to 0x0C completes normally.
- Two commands back-to-back (read then write) with a zero-wait slave -> second accept exactly at the first rsp_valid cycle; both rsp pulses at 3-cycle spacing.
